// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - per-register issue scoreboard for the dual-issue dispatch stage
// Tracks pending long-latency destinations and produces in-order issue grants and a stall request.
module issue_scoreboard #(
   parameter int DECODE_WIDTH = 2,
   parameter int NUM_REGS     = 32,
   parameter int LAT_W        = 3
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                stall,
   input  logic                                flush,
   input  logic [DECODE_WIDTH-1:0]             req_valid_i,
   input  logic [DECODE_WIDTH-1:0][1:0]        read_valid_i,
   input  logic [DECODE_WIDTH-1:0][1:0][4:0]   read_addr_i,
   input  logic [DECODE_WIDTH-1:0]             write_valid_i,
   input  logic [DECODE_WIDTH-1:0][4:0]        write_addr_i,
   input  logic [DECODE_WIDTH-1:0][LAT_W-1:0]  latency_i,
   input  logic [DECODE_WIDTH-1:0]             is_mem_i,
   input  logic                                wb_valid_i,
   input  logic [4:0]                          wb_addr_i,
   output logic [DECODE_WIDTH-1:0]             issue_o,
   output logic                                stallreq_o,
   output logic [NUM_REGS-1:0]                 busy_o
);

   localparam logic [LAT_W-1:0] LAT_WAIT = '1;
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

   logic [NUM_REGS-1:0]            busy_q, busy_d;
   logic [NUM_REGS-1:0]            wait_q, wait_d;
   logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q, cnt_d;

   logic [DECODE_WIDTH-1:0] haz;
   logic                    pair_haz;
   logic [DECODE_WIDTH-1:0] set_en;

   always_comb begin
      haz = '0;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         haz[i] = write_valid_i[i] & busy_q[write_addr_i[i]];
         for (int j = 0; j < 2; j++) begin
            haz[i] = haz[i] | (read_valid_i[i][j] & busy_q[read_addr_i[i][j]]);
         end
      end
   end

   // Slot 1 may not consume slot 0's result in the same cycle, and only one memory port exists.
   always_comb begin
      pair_haz = (is_mem_i[0] & is_mem_i[1]);
      for (int j = 0; j < 2; j++) begin
         pair_haz = pair_haz |
                    (write_valid_i[0] & read_valid_i[1][j] & (read_addr_i[1][j] == write_addr_i[0]));
      end
   end

   always_comb begin
      issue_o    = '0;
      issue_o[0] = req_valid_i[0] & ~haz[0] & ~stall & ~flush;
      issue_o[1] = issue_o[0] & req_valid_i[1] & ~haz[1] & ~pair_haz;
      stallreq_o = req_valid_i[0] & haz[0];
   end

   always_comb begin
      set_en = '0;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         set_en[i] = issue_o[i] & write_valid_i[i] & (write_addr_i[i] != 5'd0) &
                     (latency_i[i] != '0);
      end
   end

   // Later writes override earlier ones: countdown, writeback, slot 0, slot 1.
   always_comb begin
      busy_d = busy_q;
      wait_d = wait_q;
      cnt_d  = cnt_q;
      if (flush) begin
         busy_d = '0;
         wait_d = '0;
         cnt_d  = '0;
      end else begin
         if (!stall) begin
            for (int r = 0; r < NUM_REGS; r++) begin
               if (busy_q[r] && !wait_q[r]) begin
                  if (cnt_q[r] > LAT_ONE) begin
                     cnt_d[r] = cnt_q[r] - LAT_ONE;
                  end else begin
                     busy_d[r] = 1'b0;
                     cnt_d[r]  = '0;
                  end
               end
            end
         end
         if (wb_valid_i && busy_q[wb_addr_i] && wait_q[wb_addr_i]) begin
            busy_d[wb_addr_i] = 1'b0;
            wait_d[wb_addr_i] = 1'b0;
         end
         for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (set_en[i]) begin
               busy_d[write_addr_i[i]] = 1'b1;
               if (latency_i[i] == LAT_WAIT) begin
                  wait_d[write_addr_i[i]] = 1'b1;
                  cnt_d[write_addr_i[i]]  = '0;
               end else begin
                  wait_d[write_addr_i[i]] = 1'b0;
                  cnt_d[write_addr_i[i]]  = latency_i[i];
               end
            end
         end
      end
      busy_d[0] = 1'b0;
      wait_d[0] = 1'b0;
      cnt_d[0]  = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         wait_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         wait_q <= wait_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_o = busy_q;

endmodule
